p2s_rr_sched: RTL and testbench
===============================

Name: p2s_rr_sched

Overview:
- Round-robin scheduler that shares one serial output lane among N parallel-word requesters.
- Arbitrates between pending requests, captures the winner's word and acknowledges it.
- Shifts the word out MSB-first with a first-bit sync marker and a channel tag, then inserts a programmable idle gap.
- Sits between the parallel producers and the single serial link; it owns sequencing of the shared serializer resource.

Parameters:
- width, 8, data word width in bits; must be >= 2.
- n_req, 4, number of requesters; must be >= 2.
- gap_cyc, 1, idle cycles inserted after each word; 0 means back-to-back words.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  n_req  per-requester request; held with data until acked.
- data_in  input  n_req*width  flattened words; requester i occupies bits [i*width +: width].
- req_ack  output  n_req  one-cycle pulse to the requester whose word was captured.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  high in every cycle that carries a data (or parity) bit.
- ser_sync  output  1  high only in the first-bit cycle of a word.
- ser_ch  output  clog2(n_req)  channel id of the word in flight; held constant for the whole word.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values: every output is 0; state is IDLE; bit counter is 0; round-robin pointer is 0.
- All outputs are registered.
- States:
  - IDLE: no word in flight.
  - SHIFT: bits are being sent.
  - GAP: counts gap_cyc cycles with ser_valid=0 and ser_out=0.
- Arbitration point: a cycle in which any of the following holds:
  - state is IDLE;
  - state is SHIFT on the last bit and gap_cyc=0;
  - state is GAP on its last cycle.
- Round-robin grant: at an arbitration point with |req=1, the winner is the first asserted req at or after the pointer, searching upward with wrap. The pointer then becomes winner+1 mod n_req.
- Capture (arbitration in cycle T):
  - At edge T+1 the word is loaded into the shift register.
  - During cycle T+1: req_ack[winner]=1, ser_sync=1, ser_valid=1, ser_out=data[width-1], ser_ch=winner; state is SHIFT.
- Shifting:
  - Bits go out MSB-first, one per cycle, across cycles T+1..T+width.
  - Then GAP for gap_cyc cycles (skipped if gap_cyc=0), then IDLE.
- Requester handshake:
  - Drop req at the edge after seeing req_ack. A req still high at the next arbitration point counts as a new request.
  - data_in is sampled only at the capture edge.
- No request at an arbitration point: go to IDLE (or stay there); busy=0.
- Simultaneous requests: exactly one grant per arbitration point; the others wait, with no loss.
- Reset mid-word: all outputs return to 0 immediately and the partial word is discarded. No re-send happens; the requester was already acked.
- ser_ch changes only at a capture edge.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined: one extra bit follows the LSB, equal to the XOR of the captured word (even parity). ser_valid=1 and ser_sync=0 in that cycle. A word occupies width+1 cycles, and "last bit" refers to the parity bit.
- Undefined: a word is exactly width cycles; no parity logic is present.

Decomposition:
- Package p2s_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - clog2-derived widths for the channel id and bit counter;
  - gap counter width.
- Sub-module p2s_rr_arb:
  - combinational masked priority search;
  - registered pointer, updated only on grant.
- Top level: FSM, shift register, counters, output registers.

Test Plan (width=8, n_req=4, gap_cyc=1 unless noted):
- Single request: req[2]=1 with data 0xA5 in cycle T.
  - req_ack[2] in T+1 only.
  - ser_out 1,0,1,0,0,1,0,1 over T+1..T+8; ser_sync only at T+1; ser_ch=2; ser_valid for 8 cycles.
  - T+9 gap with valid=0; busy falls at T+10.
- Simultaneous requests after reset: req=4'b1111, words 0x11,0x22,0x33,0x44.
  - Words are served in channel order 0,1,2,3, with sync pulses 9 cycles apart.
  - Each ack precedes its word's bits.
- Fairness: ch0 and ch3 re-raise req immediately after each ack, for 6 words.
  - Grant sequence is 0,3,0,3,0,3; ch1 and ch2 are never acked.
- Back-to-back with gap_cyc=0: ch1=0xFF, then ch2=0x00.
  - 16 consecutive ser_valid cycles; sync at cycles 1 and 9; ser_ch goes 1 then 2 at the boundary.
- Reset mid-word: reset_n low during the 4th bit of a ch1 word, then release, with ch1 and ch2 requesting.
  - All outputs read 0 during reset.
  - After release, ch1 is granted first because the pointer restarts at 0.
  - No extra req_ack for the aborted word.
- With P2S_PARITY_EN:
  - 0xA5 produces a 9th bit of 0; 0x07 produces a 9th bit of 1.
  - ser_valid spans 9 cycles; the next sync comes 10 cycles after the previous one.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and width helpers for the p2s_rr_sched round-robin serializer.
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_w(input int n_req);
    return idx_w(n_req);
  endfunction

  function automatic int cnt_w(input int n_bits);
    return idx_w(n_bits);
  endfunction

  function automatic int gap_w(input int gap_cyc);
    return idx_w(gap_cyc);
  endfunction

endpackage

// File: rtl/p2s_rr_sched_if.sv
// Producer-side request/data bundle and serial-lane outputs of p2s_rr_sched.
interface p2s_rr_sched_if
  import p2s_pkg::*;
#(
  parameter int width = 8,
  parameter int n_req = 4
);
  localparam int CH_W = ch_w(n_req);

  logic [n_req-1:0]       req;
  logic [n_req*width-1:0] data_in;
  logic [n_req-1:0]       req_ack;
  logic                   ser_out;
  logic                   ser_valid;
  logic                   ser_sync;
  logic [CH_W-1:0]        ser_ch;
  logic                   busy;

  modport master (
    output req, data_in,
    input  req_ack, ser_out, ser_valid, ser_sync, ser_ch, busy
  );

  modport slave (
    input  req, data_in,
    output req_ack, ser_out, ser_valid, ser_sync, ser_ch, busy
  );
endinterface

// File: rtl/p2s_rr_arb.sv
// Round-robin arbiter: combinational search from the pointer upward with wrap;
// the pointer advances past the winner only when a grant is taken.
module p2s_rr_arb
  import p2s_pkg::*;
#(
  parameter int n_req = 4,
  parameter int CH_W  = ch_w(n_req)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [n_req-1:0] req,
  input  logic             arb_en,
  output logic             grant_valid,
  output logic [CH_W-1:0]  grant_idx
);

  logic [CH_W-1:0] ptr_r;
  logic [CH_W-1:0] cand_idx_s;
  logic            hit_s;
  int              cand_s;

  // First asserted request at or after the pointer, searching upward with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_s      = 0;
    cand_idx_s  = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < n_req; i++) begin
      cand_s      = int'(ptr_r) + i;
      cand_s      = (cand_s >= n_req) ? (cand_s - n_req) : cand_s;
      cand_idx_s  = CH_W'(cand_s);
      hit_s       = req[cand_idx_s] && !grant_valid;
      grant_idx   = hit_s ? cand_idx_s : grant_idx;
      grant_valid = grant_valid | req[cand_idx_s];
    end
  end

  // Pointer moves to winner+1 (mod n_req) on each granted arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (arb_en && grant_valid) begin
      ptr_r <= (grant_idx == CH_W'(n_req - 1)) ? '0 : (grant_idx + CH_W'(1));
    end
  end

endmodule

// File: rtl/p2s_rr_sched.sv
// Round-robin parallel-to-serial scheduler: MSB-first words with sync marker,
// channel tag and idle gap. Define P2S_PARITY_EN to append an even-parity bit.
module p2s_rr_sched
  import p2s_pkg::*;
#(
  parameter int width   = 8,
  parameter int n_req   = 4,
  parameter int gap_cyc = 1
) (
  input logic           clk,
  input logic           reset_n,
  p2s_rr_sched_if.slave bus
);

`ifdef P2S_PARITY_EN
  localparam int N_BITS = width + 1;
`else
  localparam int N_BITS = width;
`endif
  localparam int CH_W     = ch_w(n_req);
  localparam int CNT_W    = cnt_w(N_BITS);
  localparam int GAP_W    = gap_w(gap_cyc);
  localparam int LAST_BIT = N_BITS - 1;
  localparam int GAP_LAST = (gap_cyc > 0) ? (gap_cyc - 1) : 0;
  localparam bit NO_GAP   = (gap_cyc == 0);

`ifdef P2S_PARITY_EN
  function automatic logic even_parity(input logic [width-1:0] w);
    return ^w;
  endfunction
`endif

  state_e             state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic [width-1:0]   shreg_r;
  logic [n_req-1:0]   req_ack_r;
  logic               ser_out_r;
  logic               ser_valid_r;
  logic               ser_sync_r;
  logic [CH_W-1:0]    ser_ch_r;
  logic               busy_r;
`ifdef P2S_PARITY_EN
  logic               parity_r;
`endif

  logic               grant_valid_s;
  logic [CH_W-1:0]    grant_idx_s;
  logic               arb_pt_s;
  logic               last_bit_s;
  logic               gap_done_s;
  logic               next_bit_s;
  logic [width-1:0]   word_s;

  p2s_rr_arb #(.n_req(n_req), .CH_W(CH_W)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (bus.req),
    .arb_en      (arb_pt_s),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Arbitration-point decode and selection of the winner's word / next bit.
  always_comb begin
    last_bit_s = (bit_cnt_r == CNT_W'(LAST_BIT));
    gap_done_s = (gap_cnt_r == GAP_W'(GAP_LAST));
    word_s     = bus.data_in[int'(grant_idx_s)*width +: width];
`ifdef P2S_PARITY_EN
    next_bit_s = (bit_cnt_r == CNT_W'(width - 1)) ? parity_r : shreg_r[width-1];
`else
    next_bit_s = shreg_r[width-1];
`endif
    arb_pt_s   = 1'b0;
    case (state_r)
      IDLE:    arb_pt_s = 1'b1;
      SHIFT:   arb_pt_s = last_bit_s && NO_GAP;
      GAP:     arb_pt_s = gap_done_s;
      default: arb_pt_s = 1'b1;
    endcase
  end

  // Sequencer: capture on grant, shift out, gap, and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      shreg_r     <= '0;
      req_ack_r   <= '0;
      ser_out_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      ser_sync_r  <= 1'b0;
      ser_ch_r    <= '0;
      busy_r      <= 1'b0;
`ifdef P2S_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      req_ack_r  <= '0;
      ser_sync_r <= 1'b0;
      if (arb_pt_s) begin
        if (grant_valid_s) begin
          state_r                <= SHIFT;
          bit_cnt_r              <= '0;
          gap_cnt_r              <= '0;
          shreg_r                <= {word_s[width-2:0], 1'b0};
          req_ack_r[grant_idx_s] <= 1'b1;
          ser_out_r              <= word_s[width-1];
          ser_valid_r            <= 1'b1;
          ser_sync_r             <= 1'b1;
          ser_ch_r               <= grant_idx_s;
          busy_r                 <= 1'b1;
`ifdef P2S_PARITY_EN
          parity_r               <= even_parity(word_s);
`endif
        end else begin
          state_r     <= IDLE;
          bit_cnt_r   <= '0;
          gap_cnt_r   <= '0;
          ser_out_r   <= 1'b0;
          ser_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      end else begin
        case (state_r)
          SHIFT: begin
            if (!last_bit_s) begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              ser_out_r <= next_bit_s;
              shreg_r   <= {shreg_r[width-2:0], 1'b0};
            end else begin
              state_r     <= GAP;
              bit_cnt_r   <= '0;
              gap_cnt_r   <= '0;
              ser_out_r   <= 1'b0;
              ser_valid_r <= 1'b0;
            end
          end
          GAP: gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          default: begin
            state_r     <= IDLE;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.req_ack   = req_ack_r;
  assign bus.ser_out   = ser_out_r;
  assign bus.ser_valid = ser_valid_r;
  assign bus.ser_sync  = ser_sync_r;
  assign bus.ser_ch    = ser_ch_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_p2s_rr_sched.sv
// Directed self-checking bench for p2s_rr_sched (gap_cyc=1 and gap_cyc=0 instances).
module tb_p2s_rr_sched;
  import p2s_pkg::*;

`ifdef P2S_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int PER1 = NB + 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  p2s_rr_sched_if #(.width(8), .n_req(4)) if1 ();
  p2s_rr_sched_if #(.width(8), .n_req(4)) if0 ();

  p2s_rr_sched #(.width(8), .n_req(4), .gap_cyc(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );
  p2s_rr_sched #(.width(8), .n_req(4), .gap_cyc(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] ack, input logic v, input logic s,
                                     input logic [1:0] ch, input logic o, input logic b);
    return {22'd0, ack, v, s, ch, o, b};
  endfunction

  function automatic logic [31:0] snap1();
    return {22'd0, if1.req_ack, if1.ser_valid, if1.ser_sync, if1.ser_ch, if1.ser_out, if1.busy};
  endfunction

  function automatic logic [31:0] snap0();
    return {22'd0, if0.req_ack, if0.ser_valid, if0.ser_sync, if0.ser_ch, if0.ser_out, if0.busy};
  endfunction

  // Bit pos of a word on the wire: MSB first, position 8 is the even parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int pos);
    logic [7:0] t;
    t = w << pos;
    return (pos < 8) ? t[7] : ^w;
  endfunction

  // One request on ch into an idle dut1; checks every cycle through busy falling.
  task automatic run_single(input int ch, input logic [7:0] w, input string tag);
    logic [31:0] e;
    if1.data_in[ch*8 +: 8] = w;
    if1.req[ch] = 1'b1;
    for (int c = 0; c < NB + 2; c++) begin
      @(negedge clk);
      if (c < NB)
        e = mk((c == 0) ? 4'(1 << ch) : 4'b0000, 1'b1, c == 0, 2'(ch), exp_bit(w, c), 1'b1);
      else
        e = mk(4'b0000, 1'b0, 1'b0, 2'(ch), 1'b0, c == NB);
      chk($sformatf("%s_c%0d", tag, c), snap1(), e);
      if1.req = if1.req & ~if1.req_ack;
    end
    if1.req[ch] = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    logic [7:0]  w;
    int          k;
    int          acks;

    if1.req = '0; if1.data_in = '0;
    if0.req = '0; if0.data_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst1", snap1(), 32'd0);
    chk("rst0", snap0(), 32'd0);
    reset_n = 1'b1;

    // All four requesting after reset: served 0,1,2,3
    if1.data_in = 32'h44332211;
    if1.req     = 4'b1111;
    for (int c = 0; c < 4 * PER1; c++) begin
      @(negedge clk);
      k = c / PER1;
      w = 8'(8'h11 * (k + 1));
      if ((c % PER1) < NB)
        e = mk(((c % PER1) == 0) ? 4'(1 << k) : 4'b0000, 1'b1, (c % PER1) == 0,
               2'(k), exp_bit(w, c % PER1), 1'b1);
      else
        e = mk(4'b0000, 1'b0, 1'b0, 2'(k), 1'b0, 1'b1);
      chk($sformatf("rr4_c%0d", c), snap1(), e);
      if1.req = if1.req & ~if1.req_ack;
    end
    @(negedge clk);
    chk("rr4_idle", snap1(), mk(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0));

    // Fairness: ch0 and ch3 keep requesting
    if1.data_in = 32'h3C0000C3;
    if1.req     = 4'b1001;
    k = 0;
    for (int c = 0; c < 200 && k < 6; c++) begin
      @(negedge clk);
      if (if1.req_ack != 4'b0000) begin
        chk($sformatf("fair_g%0d", k), 32'(if1.req_ack), (k % 2 == 0) ? 32'd1 : 32'd8);
        k++;
      end
    end
    if1.req = 4'b0000;
    chk("fair_cnt", k, 6);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!if1.busy) break;
    end
    chk("fair_idle", 32'(if1.busy), 32'd0);

    // Single requests
    run_single(2, 8'hA5, "one");
    run_single(0, 8'h07, "p07");

    // Back-to-back words with no gap on dut0
    if0.data_in = 32'h0000FF00;
    if0.req     = 4'b0110;
    for (int c = 0; c < 2 * NB; c++) begin
      @(negedge clk);
      k = c / NB;
      w = (k == 0) ? 8'hFF : 8'h00;
      e = mk(((c % NB) == 0) ? 4'(2 << k) : 4'b0000, 1'b1, (c % NB) == 0,
             2'(1 + k), exp_bit(w, c % NB), 1'b1);
      chk($sformatf("b2b_c%0d", c), snap0(), e);
      if0.req = if0.req & ~if0.req_ack;
    end
    @(negedge clk);
    chk("b2b_idle", snap0(), mk(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0));

    // Reset during the 4th bit of a ch1 word (0x5A: 0,1,0,1,...)
    if1.data_in = 32'h00005A00;
    if1.req     = 4'b0010;
    @(negedge clk);
    chk("mid_ack", snap1(), mk(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1));
    if1.req = if1.req & ~if1.req_ack;
    @(negedge clk);
    chk("mid_b1", snap1(), mk(4'b0000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1));
    @(negedge clk);
    chk("mid_b2", snap1(), mk(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1));
    @(negedge clk);
    chk("mid_b3", snap1(), mk(4'b0000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1));
    reset_n     = 1'b0;
    if1.data_in = 32'h00815A00;
    if1.req     = 4'b0110;
    #1;
    chk("mid_rst1", snap1(), 32'd0);
    chk("mid_rst0", snap0(), 32'd0);
    @(negedge clk);
    chk("mid_rst1b", snap1(), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_regrant", snap1(), mk(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1));
    if1.req = if1.req & ~if1.req_ack;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if1.req_ack != 4'b0000) begin
        chk("mid_next", snap1(), mk(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1));
        acks++;
      end
      if1.req = if1.req & ~if1.req_ack;
      if (!if1.busy && if1.req == 4'b0000) break;
    end
    chk("mid_ack_cnt", acks, 1);
    chk("mid_idle", 32'(if1.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
